div_axis_unit: RTL and testbench

- Iterative radix-2 integer divider; the responder/producer end of the divisor/dividend stream handshake that the EXE stage drives for DIV/DIVU.
- Accepts one operand pair and performs one quotient bit per cycle.
- Returns {quotient, remainder} on a one-cycle valid pulse; the EXE stage writes the quotient to LO and the remainder to HI.
- Sits beside the ALU in the execute stage; one instance per signedness mode, or a single instance with `div_signed` driven per op.

---
 rtl/div_axis_unit_pkg.sv | 18 +
 rtl/div_abs_neg.sv | 13 +
 rtl/div_axis_unit.sv | 155 +++++++++++++++
 tb/tb_div_axis_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_axis_unit_pkg.sv
// Shared definitions for the iterative radix-2 divider.
package div_axis_unit_pkg;

  // Default operand width and the derived result layout.
  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_OUT_WD  = 2 * DIV_WIDTH;
  localparam int unsigned DIV_REM_LSB = 0;
  localparam int unsigned DIV_QUO_LSB = DIV_WIDTH;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivCalc = 2'd1,
    DivFix  = 2'd2,
    DivDone = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate: absolute value of operands and result sign fix.
module div_abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] din_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] dout_o
);

  // Wraps at WIDTH bits, so the most negative value maps onto itself.
  assign dout_o = neg_i ? (~din_i + WIDTH'(1)) : din_i;

endmodule

// File: rtl/div_axis_unit.sv
// Iterative radix-2 integer divider with stream-style operand handshake.
// One quotient bit per cycle; result {quotient, remainder} on a one-cycle valid pulse.
module div_axis_unit
  import div_axis_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_signed,
  input  logic               cancel,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e state_q, state_d;

  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   rem_q;      // partial remainder (always below the divisor)
  logic [WIDTH-1:0]   quo_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_quo_q;
  logic               neg_rem_q;

  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [2*WIDTH-1:0] dout_q;

  logic               accept;
  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   dvd_abs, dvs_abs;
  logic [WIDTH:0]     shifted, diff;
  logic               q_bit;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept = (state_q == DivIdle) && ready_q && s_axis_divisor_tvalid &&
                  s_axis_dividend_tvalid && !cancel;

  assign dvd_neg = div_signed & s_axis_dividend_tdata[WIDTH-1];
  assign dvs_neg = div_signed & s_axis_divisor_tdata[WIDTH-1];

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
    .din_i  (s_axis_dividend_tdata),
    .neg_i  (dvd_neg),
    .dout_o (dvd_abs)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (
    .din_i  (s_axis_divisor_tdata),
    .neg_i  (dvs_neg),
    .dout_o (dvs_abs)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .din_i  (quo_q),
    .neg_i  (neg_quo_q),
    .dout_o (quo_fix)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .din_i  (rem_q),
    .neg_i  (neg_rem_q),
    .dout_o (rem_fix)
  );

  // Trial subtraction; the extra top bit is the borrow / sign of the difference.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign q_bit   = ~diff[WIDTH];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DivIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cancel aborts CALC/FIX but never a pulse already in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivIdle: if (accept) state_d = DivCalc;
      DivCalc: begin
        if (cancel) begin
          state_d = DivIdle;
        end else if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = DivFix;
        end
      end
      DivFix:  state_d = cancel ? DivIdle : DivDone;
      DivDone: state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
  end

  // Output next-state: ready tracks the upcoming IDLE, valid follows an uncancelled FIX.
  always_comb begin
    ready_d = (state_d == DivIdle);
    valid_d = (state_q == DivFix) && !cancel;
  end

  // Registered handshake outputs and result hold register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      ready_q <= ready_d;
      valid_q <= valid_d;
      if (valid_d) begin
        dout_q <= {quo_fix, rem_fix};
      end
    end
  end

  // Operand capture and one restoring-division step per CALC cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= dvd_abs;
      dvs_q     <= dvs_abs;
      neg_quo_q <= dvd_neg ^ dvs_neg;
      neg_rem_q <= dvd_neg;
    end else if (state_q == DivCalc) begin
      cnt_q <= cnt_q + CntW'(1);
      rem_q <= q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], q_bit};
    end
  end

  assign s_axis_divisor_tready  = ready_q;
  assign s_axis_dividend_tready = ready_q;
  assign m_axis_dout_tvalid     = valid_q;
  assign m_axis_dout_tdata      = dout_q;

endmodule

// File: tb/tb_div_axis_unit.sv
// Self-checking bench for div_axis_unit (WIDTH = 32) with an expected-result queue.
module tb_div_axis_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;  // edge (after accept) at which a consumer samples tvalid high

  logic          clk = 1'b0;
  logic          resetn;
  logic          div_signed;
  logic          cancel;
  logic          dvs_valid, dvd_valid;
  logic          dvs_ready, dvd_ready;
  logic [W-1:0]  dvs_data, dvd_data;
  logic          dout_valid;
  logic [2*W-1:0] dout_data;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  div_axis_unit #(.WIDTH(W)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .div_signed             (div_signed),
    .cancel                 (cancel),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tready  (dvs_ready),
    .s_axis_divisor_tdata   (dvs_data),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_ready),
    .s_axis_dividend_tdata  (dvd_data),
    .m_axis_dout_tvalid     (dout_valid),
    .m_axis_dout_tdata      (dout_data)
  );

  // Counts result pulses so that aborted operations can be shown to produce none.
  always @(posedge clk) begin
    if (dout_valid) pulse_cnt <= pulse_cnt + 1;
  end

  // Reference: C-style truncating division, with the divide-by-zero and overflow cases.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = (sgn && a[W-1]) ? W'(1) : '1;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else if (sgn) begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Waits for tready, presents one operand pair for a single cycle; returns just after E0.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input logic [2*W-1:0] exp, input bit push);
    int t = 0;
    while (!dvs_ready && t < 60) begin
      @(posedge clk); #1; t++;
    end
    if (!dvs_ready) begin
      n_checks++; n_fail++;
      $display("FAIL start_ready_timeout: tready=%b required 1", dvs_ready);
    end
    div_signed = sgn;
    dvd_data   = a;
    dvs_data   = b;
    dvd_valid  = 1'b1;
    dvs_valid  = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
  endtask

  // Returns the edge index (relative to the accept edge) at which tvalid is sampled high.
  task automatic wait_valid(output int edge_idx);
    int c = 0;
    while (!dout_valid && c < 100) begin
      @(posedge clk); #1; c++;
    end
    edge_idx = dout_valid ? c + 1 : -1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (dvs_ready !== 1'b0 || dvd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b%b required 00", dvs_ready, dvd_ready);
    end
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b required 0", dout_valid);
    end
    n_checks++;
    if (dout_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", dout_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dvs_ready !== 1'b1 || dvd_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: got %b%b required 11", dvs_ready, dvd_ready);
    end
  endtask

  task automatic test_unsigned_basic();
    int e;
    logic [2*W-1:0] exp;
    start_op(32'd100, 32'd7, 1'b0, {32'h0000_000E, 32'h0000_0002}, 1'b1);
    n_checks++;
    if (dvs_ready !== 1'b0 || dvd_ready !== 1'b0) begin
      n_fail++; $display("FAIL accept_ready_drop: got %b%b required 00", dvs_ready, dvd_ready);
    end
    wait_valid(e);
    n_checks++;
    if (e != LAT) begin
      n_fail++; $display("FAIL udiv_latency: got %0d required %0d", e, LAT);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (dout_data !== exp) begin
      n_fail++; $display("FAIL udiv_100_7: got %h required %h", dout_data, exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL udiv_pulse_width: tvalid=%b required 0", dout_valid);
    end
    n_checks++;
    if (dvs_ready !== 1'b1) begin
      n_fail++; $display("FAIL udiv_ready_after: got %b required 1", dvs_ready);
    end
  endtask

  task automatic test_signed_table();
    logic [W-1:0]   ta [4] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000, 32'd5};
    logic [W-1:0]   tb [4] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
    logic           ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2*W-1:0] te [4] = '{{32'hFFFF_FFFD, 32'hFFFF_FFFF}, {32'hFFFF_FFFD, 32'h0000_0001},
                               {32'h8000_0000, 32'h0000_0000}, {32'hFFFF_FFFF, 32'h0000_0005}};
    int e;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i], ts[i], te[i], 1'b1);
      wait_valid(e);
      n_checks++;
      if (e != LAT) begin
        n_fail++; $display("FAIL table%0d_latency: got %0d required %0d", i, e, LAT);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (dout_data !== exp) begin
        n_fail++; $display("FAIL table%0d_data: got %h required %h", i, dout_data, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cancel();
    int e, p0;
    logic [2*W-1:0] held, exp;
    held = dout_data;
    start_op(32'd1000, 32'd3, 1'b0, '0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;  // 10th CALC edge
    cancel = 1'b0;
    n_checks++;
    if (dvs_ready !== 1'b1) begin
      n_fail++; $display("FAIL cancel_ready: got %b required 1", dvs_ready);
    end
    p0 = pulse_cnt;
    repeat (40) begin @(posedge clk); #1; end
    n_checks++;
    if (pulse_cnt != p0) begin
      n_fail++; $display("FAIL cancel_no_pulse: pulses %0d required %0d", pulse_cnt, p0);
    end
    n_checks++;
    if (dout_data !== held) begin
      n_fail++; $display("FAIL cancel_data_held: got %h required %h", dout_data, held);
    end
    start_op(32'd9, 32'd3, 1'b0, {32'd3, 32'd0}, 1'b1);
    wait_valid(e);
    n_checks++;
    if (e != LAT) begin
      n_fail++; $display("FAIL after_cancel_latency: got %0d required %0d", e, LAT);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (dout_data !== exp) begin
      n_fail++; $display("FAIL after_cancel_9_3: got %h required %h", dout_data, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_valid();
    int p0;
    p0 = pulse_cnt;
    dvs_data  = 32'd4;
    dvs_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dvs_ready !== 1'b1) begin
        n_fail++; $display("FAIL single_valid_c%0d: tready=%b required 1", i, dvs_ready);
      end
    end
    dvs_valid = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    n_checks++;
    if (pulse_cnt != p0) begin
      n_fail++; $display("FAIL single_valid_pulse: pulses %0d required %0d", pulse_cnt, p0);
    end
  endtask

  task automatic test_reset_mid();
    int e, p0;
    logic [2*W-1:0] exp;
    start_op(32'd100, 32'd7, 1'b0, '0, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    p0 = pulse_cnt;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || dout_data !== '0) begin
      n_fail++; $display("FAIL midreset_out: valid=%b data=%h required 0/0", dout_valid, dout_data);
    end
    n_checks++;
    if (dvs_ready !== 1'b0 || dvd_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ready: got %b%b required 00", dvs_ready, dvd_ready);
    end
    #10 resetn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dvs_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_release_ready: got %b required 1", dvs_ready);
    end
    repeat (40) begin @(posedge clk); #1; end
    n_checks++;
    if (pulse_cnt != p0) begin
      n_fail++; $display("FAIL midreset_no_pulse: pulses %0d required %0d", pulse_cnt, p0);
    end
    start_op(32'd100, 32'd7, 1'b0, {32'h0000_000E, 32'h0000_0002}, 1'b1);
    wait_valid(e);
    exp = exp_q.pop_front();
    n_checks++;
    if (e != LAT || dout_data !== exp) begin
      n_fail++; $display("FAIL midreset_fresh: edge %0d data %h required %0d %h",
                         e, dout_data, LAT, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int e;
    logic [W-1:0] a, b;
    logic s;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? '0 : ((i % 2 == 0) ? W'($urandom_range(1, 5000)) : W'($urandom));
      s = 1'(i % 2);
      start_op(a, b, s, model(a, b, s), 1'b1);
      wait_valid(e);
      n_checks++;
      if (e != LAT) begin
        n_fail++; $display("FAIL b2b%0d_latency: got %0d required %0d", i, e, LAT);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (dout_data !== exp) begin
        n_fail++; $display("FAIL b2b%0d_data a=%h b=%h s=%b: got %h required %h",
                           i, a, b, s, dout_data, exp);
      end
      @(posedge clk); #1;
      // Ready again on the edge the pulse ends: next accept lands W+3 edges after this one.
      n_checks++;
      if (dvs_ready !== 1'b1 || dout_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b%0d_turnaround: ready=%b valid=%b required 1/0",
                           i, dvs_ready, dout_valid);
      end
    end
  endtask

  initial begin
    resetn     = 1'b0;
    div_signed = 1'b0;
    cancel     = 1'b0;
    dvs_valid  = 1'b0;
    dvd_valid  = 1'b0;
    dvs_data   = '0;
    dvd_data   = '0;
    test_reset();
    test_unsigned_basic();
    test_signed_table();
    test_cancel();
    test_single_valid();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
